// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state codes,
// default widths and word-alignment helpers.
package ifetch_ctrl_pkg;

    localparam int unsigned PC_W_DEFAULT = 32;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_RUN  = 2'd1;
    localparam fetch_state_t ST_HALT = 2'd2;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

    // True when the two low address bits describe a word-aligned byte address.
    function automatic logic word_aligned(input logic [1:0] low_bits);
        return (low_bits & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus: instruction-memory read port, downstream pipeline
// control (stall/flush/redirect) and the IF/ID register outputs.
interface ifetch_ctrl_if
    import ifetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEFAULT
);

    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] imem_pc;
    logic [31:0]     imem_instruction;
    logic [PC_W-1:0] ifid_pc;
    logic [PC_W-1:0] ifid_pc4;
    logic [31:0]     ifid_instr;
    logic            ifid_valid;

    modport master (
        input  stall, flush, redirect_valid, redirect_pc, imem_instruction,
        output imem_pc, ifid_pc, ifid_pc4, ifid_instr, ifid_valid
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_pc, imem_instruction,
        input  imem_pc, ifid_pc, ifid_pc4, ifid_instr, ifid_valid
    );

endinterface

// File: rtl/ifetch_ctrl_ifid_reg.sv
// IF/ID pipeline register: load captures a valid entry, clear drops
// validity while keeping the payload, otherwise contents are held.
module ifetch_ctrl_ifid_reg #(
    parameter int unsigned DATA_W = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    // Payload and valid bit; load takes priority over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: PC register, IDLE/RUN/HALT control,
// redirect/stall/flush handling, end-of-program and illegal-target detection.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W       = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int unsigned     IMEM_WORDS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    ifetch_ctrl_if.master       bus,
    output logic [31:0]         fetch_count,
    output logic                halted,
    output logic                fault,
    output logic [1:0]          state
);

    localparam logic [PC_W+1:0] PC_LIMIT = (PC_W+2)'(4 * IMEM_WORDS);
    localparam logic [PC_W-1:0] LAST_PC  = PC_W'(4 * IMEM_WORDS - 4);
    localparam int unsigned     IFID_W   = 2 * PC_W + 32;

    fetch_state_t    state_q;
    fetch_state_t    state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus4;
    logic [31:0]     count_next;
    logic            fault_next;
    logic            redirect_bad;
    logic            ifid_load;
    logic            ifid_clear;
    logic [IFID_W-1:0] ifid_d;
    logic [IFID_W-1:0] ifid_q;

    assign pc_plus4 = pc + PC_W'(4);
    assign ifid_d   = {pc, pc_plus4, bus.imem_instruction};

    // Next-state, PC and IF/ID control; redirect > flush > stall > normal fetch.
    always_comb begin
        redirect_bad = !word_aligned(bus.redirect_pc[1:0])
                       || ({2'b00, bus.redirect_pc} >= PC_LIMIT);
        state_next   = state_q;
        pc_next      = pc;
        count_next   = fetch_count;
        fault_next   = fault;
        ifid_load    = 1'b0;
        ifid_clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ifid_clear = 1'b1;
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    ifid_clear = 1'b1;
                    if (redirect_bad) begin
                        fault_next = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        pc_next = bus.redirect_pc;
                    end
                end else if (bus.flush) begin
                    ifid_clear = 1'b1;
                end else if (!bus.stall) begin
                    ifid_load  = 1'b1;
                    count_next = fetch_count + 32'd1;
                    if (pc == LAST_PC) state_next = ST_HALT;
                    else               pc_next    = pc_plus4;
                end
            end
            ST_HALT: begin
                // The final captured instruction stays visible only while stalled.
                if (!bus.stall || bus.flush) ifid_clear = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
                ifid_clear = 1'b1;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc          <= RESET_PC;
            fetch_count <= '0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_next;
            pc          <= pc_next;
            fetch_count <= count_next;
            fault       <= fault_next;
        end
    end

    ifetch_ctrl_ifid_reg #(
        .DATA_W(IFID_W)
    ) u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .load  (ifid_load),
        .clear (ifid_clear),
        .d     (ifid_d),
        .q     (ifid_q),
        .valid (bus.ifid_valid)
    );

    assign {bus.ifid_pc, bus.ifid_pc4, bus.ifid_instr} = ifid_q;
    assign bus.imem_pc = pc;
    assign halted      = (state_q == ST_HALT);
    assign state       = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed vector table, hand-written end-of-program
// and reset sequences, and randomized traffic against a reference model.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] fetch_count;
    logic        halted;
    logic        fault;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_ctrl_if #(.PC_W(32)) bus ();

    ifetch_ctrl #(
        .PC_W      (32),
        .RESET_PC  (32'h0),
        .IMEM_WORDS(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .fetch_count(fetch_count),
        .halted     (halted),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    assign bus.imem_instruction = mem[bus.imem_pc[7:2]];

    // Reference model: progress flags and counters derived from the fetch rules.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
    bit          m_valid, m_fault, m_started, m_stopped;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clock();
        if (reset) begin
            m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_cnt = 0;
            m_valid = 0; m_fault = 0; m_started = 0; m_stopped = 0;
        end else if (!m_started) begin
            if (start) m_started = 1;
        end else if (!m_stopped) begin
            if (bus.redirect_valid) begin
                m_valid = 0;
                if ((bus.redirect_pc % 4) != 0 || bus.redirect_pc >= 32'd256) begin
                    m_fault   = 1;
                    m_stopped = 1;
                end else begin
                    m_pc = bus.redirect_pc;
                end
            end else if (bus.flush) begin
                m_valid = 0;
            end else if (!bus.stall) begin
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 4;
                m_instr = mem[m_pc[7:2]];
                m_valid = 1;
                m_cnt   = m_cnt + 1;
                if (m_pc == 32'd252) m_stopped = 1;
                else                 m_pc = m_pc + 4;
            end
        end else if (!bus.stall || bus.flush) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model();
        logic [31:0] exp_state;
        exp_state = m_stopped ? 32'd2 : (m_started ? 32'd1 : 32'd0);
        chk("rnd imem_pc", bus.imem_pc, m_pc);
        chk("rnd ifid_valid", 32'(bus.ifid_valid), 32'(m_valid));
        chk("rnd fetch_count", fetch_count, m_cnt);
        chk("rnd state", 32'(state), exp_state);
        chk("rnd halted", 32'(halted), 32'(m_stopped));
        chk("rnd fault", 32'(fault), 32'(m_fault));
        if (m_valid) begin
            chk("rnd ifid_pc", bus.ifid_pc, m_ipc);
            chk("rnd ifid_pc4", bus.ifid_pc4, m_ipc4);
            chk("rnd ifid_instr", bus.ifid_instr, m_instr);
        end
    endtask

    task automatic set_in(input logic r, input logic s, input logic stl, input logic fl,
                          input logic rv, input logic [31:0] rpc);
        reset = r; start = s; bus.stall = stl; bus.flush = fl;
        bus.redirect_valid = rv; bus.redirect_pc = rpc;
    endtask

    typedef struct {
        logic        rst, st, stl, fl, rv;
        logic [31:0] rpc;
        logic [31:0] e_imem, e_ipc, e_ipc4, e_instr, e_cnt;
        logic        e_valid, e_fault;
        logic [1:0]  e_state;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic stl, input logic fl,
                                input logic rv, input logic [31:0] rpc,
                                input logic [31:0] e_imem, input logic [31:0] e_ipc,
                                input logic [31:0] e_ipc4, input logic [31:0] e_instr,
                                input logic [31:0] e_cnt, input logic e_valid,
                                input logic e_fault, input logic [1:0] e_state);
        vec_t v;
        v.rst = rst; v.st = st; v.stl = stl; v.fl = fl; v.rv = rv; v.rpc = rpc;
        v.e_imem = e_imem; v.e_ipc = e_ipc; v.e_ipc4 = e_ipc4; v.e_instr = e_instr;
        v.e_cnt = e_cnt; v.e_valid = e_valid; v.e_fault = e_fault; v.e_state = e_state;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'h0000_0000;
        set_in(1, 0, 0, 0, 0, 0);

        //              rst st stl fl rv rpc      imem    ipc     ipc4    instr         cnt v f st
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,        0,      0,      0,      0,            0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0,        0,      0,      0,      0,            0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 0,        0,      0,      0,      0,            0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0,        4,      0,      4,      32'h20080001, 1, 1, 0, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0,        8,      4,      8,      32'h20090002, 2, 1, 0, 1);
        tbl[5]  = mk(0, 0, 1, 0, 0, 0,        8,      4,      8,      32'h20090002, 2, 1, 0, 1);
        tbl[6]  = mk(0, 0, 1, 0, 0, 0,        8,      4,      8,      32'h20090002, 2, 1, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,        12,     8,      12,     32'h01095020, 3, 1, 0, 1);
        tbl[8]  = mk(0, 0, 1, 0, 1, 32'h20,   32'h20, 0,      0,      0,            3, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,        32'h24, 32'h20, 32'h24, 32'h10000008, 4, 1, 0, 1);
        tbl[10] = mk(0, 0, 1, 1, 0, 0,        32'h24, 0,      0,      0,            4, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0,        32'h28, 32'h24, 32'h28, 32'h10000009, 5, 1, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 1, 32'h22,   32'h28, 0,      0,      0,            5, 0, 1, 2);
        tbl[13] = mk(0, 1, 0, 0, 1, 32'h40,   32'h28, 0,      0,      0,            5, 0, 1, 2);
        tbl[14] = mk(1, 0, 0, 0, 0, 0,        0,      0,      0,      0,            0, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 0, 0,        0,      0,      0,      0,            0, 0, 0, 1);
        tbl[16] = mk(0, 0, 1, 0, 1, 32'h100,  0,      0,      0,      0,            0, 0, 1, 2);

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].rst, tbl[i].st, tbl[i].stl, tbl[i].fl, tbl[i].rv, tbl[i].rpc);
            tick();
            chk($sformatf("vec%0d imem_pc", i), bus.imem_pc, tbl[i].e_imem);
            chk($sformatf("vec%0d ifid_valid", i), 32'(bus.ifid_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d fetch_count", i), fetch_count, tbl[i].e_cnt);
            chk($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].e_state));
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'(tbl[i].e_state == 2'd2));
            chk($sformatf("vec%0d fault", i), 32'(fault), 32'(tbl[i].e_fault));
            if (tbl[i].e_valid || tbl[i].rst) begin
                chk($sformatf("vec%0d ifid_pc", i), bus.ifid_pc, tbl[i].e_ipc);
                chk($sformatf("vec%0d ifid_pc4", i), bus.ifid_pc4, tbl[i].e_ipc4);
                chk($sformatf("vec%0d ifid_instr", i), bus.ifid_instr, tbl[i].e_instr);
            end
        end

        // Run through the whole memory to the end-of-program halt.
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (64) tick();
        chk("eop ifid_pc", bus.ifid_pc, 32'hFC);
        chk("eop ifid_instr", bus.ifid_instr, 32'h1000_003F);
        chk("eop ifid_valid", 32'(bus.ifid_valid), 32'd1);
        chk("eop halted", 32'(halted), 32'd1);
        chk("eop fetch_count", fetch_count, 32'd64);
        chk("eop imem_pc", bus.imem_pc, 32'hFC);
        set_in(0, 0, 1, 0, 0, 0); tick();
        chk("eop stall valid", 32'(bus.ifid_valid), 32'd1);
        chk("eop stall ifid_pc", bus.ifid_pc, 32'hFC);
        set_in(0, 1, 0, 0, 1, 32'h0); tick();
        chk("eop consumed valid", 32'(bus.ifid_valid), 32'd0);
        chk("eop held imem_pc", bus.imem_pc, 32'hFC);
        chk("eop held count", fetch_count, 32'd64);
        chk("eop held state", 32'(state), 32'd2);
        chk("eop no fault", 32'(fault), 32'd0);

        // Reset mid-run wins over a simultaneous redirect.
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("midrst pre imem_pc", bus.imem_pc, 32'h10);
        set_in(1, 0, 0, 0, 1, 32'h20); tick();
        chk("midrst imem_pc", bus.imem_pc, 32'h0);
        chk("midrst state", 32'(state), 32'd0);
        chk("midrst fetch_count", fetch_count, 32'd0);
        chk("midrst ifid_valid", 32'(bus.ifid_valid), 32'd0);
        set_in(0, 0, 0, 0, 0, 0); tick();
        chk("midrst idle hold", bus.imem_pc, 32'h0);
        chk("midrst idle state", 32'(state), 32'd0);

        // Randomized traffic against the reference model.
        for (int ep = 0; ep < 8; ep++) begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            set_in(1, 0, 0, 0, 0, 0); tick();
            compare_model();
            for (int c = 0; c < 300; c++) begin
                logic [31:0] rpc;
                int unsigned sel;
                sel = $urandom_range(0, 9);
                if (sel < 7)       rpc = 32'($urandom_range(0, 63)) * 32'd4;
                else if (sel == 7) rpc = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
                else if (sel == 8) rpc = 32'($urandom_range(64, 1000)) * 32'd4;
                else               rpc = $urandom;
                set_in($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 11) == 0, rpc);
                tick();
                compare_model();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
